// File: rtl/wb_arbiter2.sv
// Two-master / one-slave pipelined Wishbone arbiter in front of the on-chip RAM.
// Whole cyc-framed bus cycles are granted round-robin; outstanding transfers are counted so responses reach only their issuer.
module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [31:0]      m0_adr,
    input  logic [3:0]       m0_sel,
    input  logic [31:0]      m0_dat_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack,
    output logic             m0_err,
    output logic             m0_stall,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [31:0]      m1_adr,
    input  logic [3:0]       m1_sel,
    input  logic [31:0]      m1_dat_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             m1_stall,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [31:0]      s_adr,
    output logic [3:0]       s_sel,
    output logic [31:0]      s_dat_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_stall,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state, state_next;
    logic             last_grant, last_grant_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             full, cnt_nz, resp, accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            cnt        <= cnt_next;
        end
    end

    // Handshake: a request transfers in any cycle with stb=1 and stall=0; each
    // transfer is answered later by exactly one ack or err, in issue order.
    always_comb begin
        full   = (cnt == CNT_W'(MAX_OUTSTANDING));
        cnt_nz = (cnt != '0);
        resp   = (s_ack | s_err) & cnt_nz;

        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = 1'b1;
        m1_dat_o = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = 1'b1;

        case (state)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_cyc & m0_stb & ~full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_o  = m0_dat_i;
                m0_stall = s_stall | full;
                m0_ack   = s_ack & cnt_nz;
                m0_err   = s_err & cnt_nz;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_cyc & m1_stb & ~full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_o  = m1_dat_i;
                m1_stall = s_stall | full;
                m1_ack   = s_ack & cnt_nz;
                m1_err   = s_err & cnt_nz;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase

        accept   = s_stb & ~s_stall;
        cnt_next = cnt + CNT_W'(accept) - CNT_W'(resp);

        state_next      = state;
        last_grant_next = last_grant;
        // last_grant only records contested decisions, so back-to-back ties alternate.
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next      = last_grant ? GNT0 : GNT1;
                    last_grant_next = ~last_grant;
                end else if (m0_cyc) begin
                    state_next = GNT0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) state_next = (cnt_next == '0) ? IDLE : DRAIN;
            end
            GNT1: begin
                if (!m1_cyc) state_next = (cnt_next == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (cnt_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic against a behavioural slave,
// with request/response scoreboards checked by independent monitors.
module tb_wb_arbiter2;
    localparam int MAXO  = 4;
    localparam int CNT_W = $clog2(MAXO + 1);
    localparam logic [1:0] ST_IDLE = 2'd0, ST_GNT1 = 2'd2, ST_DRAIN = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]        m_cyc = '0, m_stb = '0, m_we = '0;
    logic [1:0][31:0]  m_adr = '0, m_dat_w = '0;
    logic [1:0][3:0]   m_sel = '0;
    logic [1:0][31:0]  m_dat_r;
    logic [1:0]        m_ack, m_err, m_stall;
    logic              s_cyc, s_stb, s_we;
    logic [31:0]       s_adr, s_dat_o;
    logic [3:0]        s_sel;
    logic [31:0]       s_dat_i = '0;
    logic              s_ack = 1'b0, s_err = 1'b0, s_stall = 1'b0;
    logic [1:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_cnt;

    wb_arbiter2 #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
        .m0_sel(m_sel[0]), .m0_dat_i(m_dat_w[0]), .m0_dat_o(m_dat_r[0]),
        .m0_ack(m_ack[0]), .m0_err(m_err[0]), .m0_stall(m_stall[0]),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
        .m1_sel(m_sel[1]), .m1_dat_i(m_dat_w[1]), .m1_dat_o(m_dat_r[1]),
        .m1_ack(m_ack[1]), .m1_err(m_err[1]), .m1_stall(m_stall[1]),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
        .s_stall(s_stall), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // scoreboard state
    int checks = 0, errors = 0;
    logic [68:0] exp_q[$];            // {we, adr, sel, dat} expected at the slave
    logic [33:0] resp_q0[$], resp_q1[$]; // {we, err, data} expected at each master
    int pend_due[$];
    logic [32:0] pend_rsp[$];
    int slave_lat_min = 1, slave_lat_max = 1, stall_pct = 0, force_stall = 0;
    int max_pend = 0, last_resp_cyc = 0;
    int stall_cnt[2], first_acc[2], last_ack[2], start_cyc[2], ack_cnt[2], resp_at_first[2];
    logic last_err[2];
    int model_last = 1;
    int w, before0, before1;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic err_fn(input logic [31:0] a);
        return (a[7:4] == 4'hF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // behavioural RAM-like slave: in-order responses after a programmable latency
    initial begin
        forever begin
            @(negedge clk);
            if (s_cyc && s_stb && !s_stall) begin
                checks++;
                if (pend_due.size() >= MAXO) begin
                    errors++;
                    $display("FAIL outstanding_limit: %0d already outstanding, required < %0d", pend_due.size(), MAXO);
                end
                pend_due.push_back(cyc_n + int'($urandom_range(slave_lat_max, slave_lat_min)));
                pend_rsp.push_back({err_fn(s_adr), data_fn(s_adr)});
                if (pend_due.size() > max_pend) max_pend = pend_due.size();
            end
            if (s_cyc && s_stb && s_stall && force_stall > 0) force_stall--;
            if ((s_ack || s_err) && pend_due.size() > 0) begin
                void'(pend_due.pop_front());
                void'(pend_rsp.pop_front());
                last_resp_cyc = cyc_n;
            end
            @(posedge clk);
            #1;
            s_stall = (force_stall > 0) || (int'($urandom_range(99, 0)) < stall_pct);
            if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
                s_ack   = ~pend_rsp[0][32];
                s_err   = pend_rsp[0][32];
                s_dat_i = pend_rsp[0][31:0];
            end else begin
                s_ack   = 1'b0;
                s_err   = 1'b0;
                s_dat_i = $urandom;
            end
        end
    end

    // monitor: pops and compares whenever the DUT presents a response or a slave request
    initial begin
        logic [33:0] e;
        logic        empty;
        forever begin
            @(negedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m] || m_err[m]) begin
                    ack_cnt[m]++;
                    last_ack[m] = cyc_n;
                    last_err[m] = m_err[m];
                    checks++;
                    empty = (m == 0) ? (resp_q0.size() == 0) : (resp_q1.size() == 0);
                    if (empty) begin
                        errors++;
                        $display("FAIL m%0d_unexpected_resp: ack=%0b err=%0b, required no response", m, m_ack[m], m_err[m]);
                    end else begin
                        e = (m == 0) ? resp_q0.pop_front() : resp_q1.pop_front();
                        if (m_ack[m] !== ~e[32] || m_err[m] !== e[32] || (!e[33] && m_dat_r[m] !== e[31:0])) begin
                            errors++;
                            $display("FAIL m%0d_resp: ack=%0b err=%0b dat=%h, required ack=%0b err=%0b dat=%h",
                                     m, m_ack[m], m_err[m], m_dat_r[m], ~e[32], e[32], e[31:0]);
                        end
                    end
                end
            end
            if (s_cyc && s_stb && !s_stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slave_unexpected_req: adr=%h, required no request", s_adr);
                end else if ({s_we, s_adr, s_sel, s_dat_o} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL slave_req: got %h, required %h", {s_we, s_adr, s_sel, s_dat_o}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // master driver: one cyc-framed bus cycle of n transfers (we_mode 0=rd 1=wr 2=random)
    task automatic run_master(input int m, input int n, input bit abort, input int we_mode,
                              input bit fixed, input logic [31:0] adr0);
        int guard;
        logic [31:0] a;
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b1;
        start_cyc[m] = cyc_n;
        stall_cnt[m] = 0;
        first_acc[m] = -1;
        for (int i = 0; i < n; i++) begin
            a = fixed ? adr0 + 32'(4 * i) : ($urandom & 32'hFFFF_FFFC);
            m_stb[m]   = 1'b1;
            m_we[m]    = (we_mode == 2) ? 1'($urandom_range(1, 0)) : (we_mode == 1);
            m_adr[m]   = a;
            m_sel[m]   = 4'($urandom_range(15, 1));
            m_dat_w[m] = $urandom;
            guard = 0;
            @(negedge clk);
            while (m_stall[m] && guard < 400) begin
                stall_cnt[m]++;
                guard++;
                @(negedge clk);
            end
            if (m_stall[m]) begin
                checks++;
                errors++;
                $display("FAIL m%0d_accept_timeout: stall=1 after %0d cycles, required 0", m, guard);
                m_stb[m] = 1'b0;
                m_cyc[m] = 1'b0;
                return;
            end
            if (first_acc[m] < 0) begin
                first_acc[m] = cyc_n;
                resp_at_first[m] = last_resp_cyc;
            end
            exp_q.push_back({m_we[m], a, m_sel[m], m_dat_w[m]});
            if (!abort) begin
                if (m == 0) resp_q0.push_back({m_we[m], err_fn(a), data_fn(a)});
                else        resp_q1.push_back({m_we[m], err_fn(a), data_fn(a)});
            end
            @(posedge clk);
            #1;
        end
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
        if (abort) begin
            m_cyc[m] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("abort_drain_state", 64'(dbg_state), 64'(ST_DRAIN));
        end else begin
            guard = 0;
            while (((m == 0) ? resp_q0.size() : resp_q1.size()) != 0 && guard < 1000) begin
                @(negedge clk);
                #2;
                guard++;
            end
            if (((m == 0) ? resp_q0.size() : resp_q1.size()) != 0) begin
                checks++;
                errors++;
                $display("FAIL m%0d_resp_timeout: responses still missing, required none", m);
            end
            @(posedge clk);
            #1;
            m_cyc[m] = 1'b0;
        end
    endtask

    // both masters raise cyc together; the winner is the one not chosen in the previous tie
    task automatic contend(input int n0, input int n1);
        int win;
        win = (model_last == 1) ? 0 : 1;
        model_last = win;
        fork
            run_master(0, n0, 1'b0, 2, 1'b0, 32'h0);
            run_master(1, n1, 1'b0, 2, 1'b0, 32'h0);
        join
        check("contend_winner_first", 64'(first_acc[win] < first_acc[1 - win]), 64'd1);
        check("contend_handover_gap", 64'(first_acc[1 - win] - last_ack[win]), 64'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            stall_cnt[m] = 0; first_acc[m] = -1; last_ack[m] = 0; start_cyc[m] = 0;
            ack_cnt[m] = 0; resp_at_first[m] = 0; last_err[m] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        check("reset_cnt", 64'(dbg_cnt), 64'd0);
        check("reset_outputs", 64'({m_stall, m_ack, m_err, s_cyc, s_stb}), 64'({2'b11, 2'b00, 2'b00, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single m0 read, RAM latency
        before1 = ack_cnt[1];
        run_master(0, 1, 1'b0, 0, 1'b1, 32'h10);
        check("single_accept_latency", 64'(first_acc[0] - start_cyc[0]), 64'd1);
        check("single_ack_latency", 64'(last_ack[0] - start_cyc[0]), 64'd2);
        check("single_arb_stall", 64'(stall_cnt[0]), 64'd1);
        check("single_no_m1_ack", 64'(ack_cnt[1] - before1), 64'd0);

        // simultaneous requests, then a repeat tie
        contend(2, 3);
        contend(3, 2);

        // abort with two outstanding while the other master waits
        slave_lat_min = 6;
        slave_lat_max = 6;
        w = (model_last == 1) ? 0 : 1;
        model_last = w;
        before0 = ack_cnt[w];
        fork
            run_master(w, 2, 1'b1, 0, 1'b1, 32'h200);
            run_master(1 - w, 1, 1'b0, 0, 1'b1, 32'h300);
        join
        check("abort_winner_first", 64'(first_acc[w] < first_acc[1 - w]), 64'd1);
        check("abort_acks_swallowed", 64'(ack_cnt[w] - before0), 64'd0);
        check("abort_regrant_gap", 64'(first_acc[1 - w] - resp_at_first[1 - w]), 64'd2);

        // slave stall for 3 cycles then an error response
        slave_lat_min = 1;
        slave_lat_max = 1;
        force_stall = 3;
        run_master(0, 1, 1'b0, 0, 1'b1, 32'hF0);
        check("err_stall_cycles", 64'(stall_cnt[0]), 64'd4);
        check("err_received", 64'(last_err[0]), 64'd1);
        @(negedge clk);
        check("err_cnt_zero", 64'(dbg_cnt), 64'd0);

        // six pipelined writes against a 5-cycle slave
        slave_lat_min = 5;
        slave_lat_max = 5;
        max_pend = 0;
        before1 = ack_cnt[1];
        run_master(1, 6, 1'b0, 1, 1'b1, 32'h100);
        check("burst_max_outstanding", 64'(max_pend), 64'(MAXO));
        check("burst_ack_count", 64'(ack_cnt[1] - before1), 64'd6);
        check("burst_stall_cycles", 64'(stall_cnt[1]), 64'd3);

        // reset while m1 has one transfer outstanding
        slave_lat_min = 4;
        slave_lat_max = 4;
        before0 = ack_cnt[0];
        before1 = ack_cnt[1];
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_adr[1] = 32'h40; m_sel[1] = 4'hF; m_dat_w[1] = 32'h0;
        @(negedge clk);
        for (int g = 0; g < 20 && m_stall[1]; g++) @(negedge clk);
        check("rst_setup_accept", 64'(m_stall[1]), 64'd0);
        exp_q.push_back({1'b0, 32'h40, 4'hF, 32'h0});
        @(posedge clk);
        #1;
        m_stb[1] = 1'b0;
        @(negedge clk);
        check("rst_pre_state", 64'(dbg_state), 64'(ST_GNT1));
        check("rst_pre_cnt", 64'(dbg_cnt), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_cyc[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        check("rst_post_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_post_cnt", 64'(dbg_cnt), 64'd0);
        repeat (8) @(negedge clk);
        check("rst_stray_cnt", 64'(dbg_cnt), 64'd0);
        check("rst_stray_not_routed", 64'((ack_cnt[0] - before0) + (ack_cnt[1] - before1)), 64'd0);

        // random traffic from both masters
        slave_lat_min = 1;
        slave_lat_max = 4;
        stall_pct = 25;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    run_master(0, int'($urandom_range(6, 1)), 1'b0, 2, 1'b0, 32'h0);
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                end
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    run_master(1, int'($urandom_range(6, 1)), 1'b0, 2, 1'b0, 32'h0);
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                end
            end
        join
        stall_pct = 0;
        repeat (10) @(negedge clk);
        check("final_slave_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_resp_q_empty", 64'(resp_q0.size() + resp_q1.size()), 64'd0);
        check("final_state", 64'(dbg_state), 64'(ST_IDLE));
        check("final_cnt", 64'(dbg_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave pipelined Wishbone arbiter placed directly upstream of the single-port 32-bit on-chip RAM slave.
- Lets the instruction fetch port (m0) and the data port (m1) share one RAM.
- Grants whole bus cycles (cyc-framed) round-robin and tracks outstanding transfers, so every slave ack/err is routed only to the master that issued the request.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged transfers; must be >= 1.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived; not to be overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mN_cyc  in  1  master N bus cycle (N = 0,1; m0 = instruction, m1 = data).
- mN_stb  in  1  master N strobe.
- mN_we  in  1  master N write enable.
- mN_adr  in  32  master N byte address.
- mN_sel  in  4  master N byte selects.
- mN_dat_i  in  32  master N write data.
- mN_dat_o  out  32  read data to master N.
- mN_ack  out  1  ack to master N.
- mN_err  out  1  error to master N.
- mN_stall  out  1  stall to master N.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  32  to slave.
- s_sel  out  4  to slave.
- s_dat_o  out  32  write data to slave.
- s_dat_i  in  32  read data from slave.
- s_ack, s_err, s_stall  in  1 each  from slave.

Behaviour:
- State machine, registered: IDLE, GNT0, GNT1, DRAIN.
  - Registers: last_grant (1 bit), cnt (CNT_W bits).
  - Reset (rst_n=0 at clk edge): state=IDLE, last_grant=1 (m0 wins the first tie), cnt=0.
- IDLE:
  - Both mN_stall=1; all ack/err=0; s_cyc=s_stb=0.
  - Only one cyc high -> grant that master.
  - Both cyc high -> grant master != last_grant.
  - Grant takes effect next cycle (1-cycle arbitration latency); last_grant updated on the transition.
- GNTx (x granted):
  - s_cyc = mx_cyc.
  - s_stb = mx_stb & ~full, where full = (cnt == MAX_OUTSTANDING).
  - s_we/adr/sel/dat_o = mx signals.
  - mx_stall = s_stall | full.
  - mx_ack = s_ack, mx_err = s_err, mx_dat_o = s_dat_i.
  - Other master: stall=1, ack=err=0.
  - When mx_cyc=0: next state IDLE if cnt_next==0, else DRAIN.
- DRAIN:
  - s_cyc=s_stb=0; both stall=1.
  - Slave ack/err consumed and discarded (aborted cycle); decrement cnt.
  - Go to IDLE when cnt_next==0.
- Counter:
  - cnt_next = cnt + (s_stb & ~s_stall) - (s_ack | s_err).
  - Simultaneous accept and ack -> unchanged.
  - ack with cnt==0 is ignored (cnt stays 0, not routed to any master).
  - full blocks further strobes, so cnt cannot exceed MAX_OUTSTANDING.
- Unused outputs:
  - mN_dat_o = s_dat_i for the granted master, 0 otherwise.
  - s_* address/data/sel/we = 0 when not in GNTx.
- Boundaries:
  - Granted master keeps cyc high indefinitely -> other master starves (by design; masters must frame cycles).
  - Non-granted master asserting stb is held stalled; none of its requests are lost.
  - Reset mid-transfer: all state cleared on that edge; stray slave acks afterwards are ignored (cnt==0).

Test Plan:
- Single m0 read:
  - Stimulus: m0 cyc/stb at cycle 0, adr=0x10, slave acks 1 cycle after accept (RAM behaviour).
  - Response: m0_stall=1 at cycle 0; s_stb at cycle 1; m0_ack with s_dat_i at cycle 2; m1 sees no ack.
- Simultaneous request:
  - Stimulus: m0 and m1 raise cyc in the same cycle after reset.
  - Response: m0 granted first; after m0 drops cyc and cnt reaches 0, m1 is granted after 1 IDLE cycle. A repeat contention grants m1 first (alternation).
- Pipelined burst:
  - Stimulus: m1 issues 6 back-to-back writes with MAX_OUTSTANDING=4 to a slave that delays acks by 5 cycles.
  - Response: stall asserted once cnt=4; all 6 writes reach the slave with correct adr/sel/data; exactly 6 m1_acks.
- Abort:
  - Stimulus: m0 drops cyc with cnt=2 outstanding while m1 is requesting.
  - Response: state DRAIN, both acks swallowed (m0_ack=m1_ack=0), then IDLE, then m1 granted.
- Error and stall:
  - Stimulus: slave asserts s_stall for 3 cycles, then s_err instead of ack.
  - Response: granted master held stalled for 3 cycles; receives err=1, ack=0; cnt returns to 0.
- Reset mid-transfer:
  - Stimulus: rst_n=0 for 1 cycle while in GNT1 with cnt=1.
  - Response: next cycle state=IDLE, cnt=0; a late s_ack is not routed to either master.
